// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bus_pkg
// Purpose  : Shared types and constants for the RAM-backed data-bus responder.
// Revision : 1.0 - initial release
// ============================================================================
package bus_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } bus_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } resp_state_e;

endpackage : bus_pkg
`default_nettype wire

// File: rtl/bus_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : bus_lane_align
// Purpose  : Combinational byte-lane steering: store mask/replication, load
//            lane select with sign/zero extension, misalignment detection.
// Revision : 1.0 - initial release
// ============================================================================
module bus_lane_align
    import bus_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  bus_size_e   size,
    input  logic        is_unsigned,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  byte_mask,
    output logic [31:0] st_lanes,
    output logic [31:0] ld_data,
    output logic        misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = ld_word[{addr_lo, 3'b000} +: 8];
    assign w_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

    always_comb begin
        byte_mask = 4'b0000;
        st_lanes  = st_data;
        ld_data   = ld_word;
        misalign  = 1'b0;
        case (size)
            SZ_BYTE: begin
                byte_mask = 4'b0001 << addr_lo;
                st_lanes  = {4{st_data[7:0]}};
                ld_data   = {{24{~is_unsigned & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                byte_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_lanes  = {2{st_data[15:0]}};
                ld_data   = {{16{~is_unsigned & w_half[15]}}, w_half};
                misalign  = addr_lo[0];
            end
            SZ_WORD: begin
                byte_mask = 4'b1111;
                misalign  = (addr_lo != 2'b00);
            end
            default: begin
                byte_mask = 4'b0000;
                ld_data   = 32'h0000_0000;
            end
        endcase
    end

endmodule : bus_lane_align
`default_nettype wire

// File: rtl/bus_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : bus_ram_responder
// Purpose  : Load/store bus slave backed by a word RAM with programmable wait
//            states. Optional statistics counters under BUS_RAM_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bus_ram_responder
    import bus_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        busReq,
    input  logic        busWe,
    input  logic [31:0] busAddr,
    input  logic [31:0] busWData,
    input  logic [1:0]  busSize,
    input  logic        busUnsigned,
    output logic [31:0] busRData,
    output logic        busReady,
    output logic        busErr
`ifdef BUS_RAM_STATS_EN
    ,
    output logic [15:0] rdCount,
    output logic [15:0] wrCount,
    output logic [15:0] errCount
`endif
);

    localparam logic [WAIT_CNT_W-1:0] c_wait_init =
        (WAIT_STATES == 0) ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);

    resp_state_e               r_state, w_state_next;
    logic [WAIT_CNT_W-1:0]     r_cnt, w_cnt_next;

    logic [31:0]               r_addr, r_wdata, r_rdata;
    logic                      r_we, r_uns, r_err;
    bus_size_e                 r_size;

    logic [31:0]               r_mem [2**ADDR_WIDTH];

    logic                      w_in_idle, w_enter_resp, w_commit;
    logic [31:0]               w_addr, w_wdata, w_rword, w_rload, w_wrep;
    logic                      w_we, w_uns, w_hit, w_err, w_misalign;
    bus_size_e                 w_size;
    logic [3:0]                w_wmask;
    logic [ADDR_WIDTH-1:0]     w_idx;

    // With zero wait states the commit edge is also the latch edge, so the
    // live inputs stand in for the not-yet-latched request.
    assign w_in_idle = (r_state == IDLE);
    assign w_addr    = w_in_idle ? busAddr     : r_addr;
    assign w_wdata   = w_in_idle ? busWData    : r_wdata;
    assign w_we      = w_in_idle ? busWe       : r_we;
    assign w_uns     = w_in_idle ? busUnsigned : r_uns;
    assign w_size    = w_in_idle ? bus_size_e'(busSize) : r_size;

    assign w_hit   = (w_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign w_idx   = w_addr[ADDR_WIDTH+1:2];
    assign w_rword = r_mem[w_idx];
    assign w_err   = ~w_hit | (w_size == SZ_ILL) | w_misalign;

    bus_lane_align u_align (
        .addr_lo     (w_addr[1:0]),
        .size        (w_size),
        .is_unsigned (w_uns),
        .st_data     (w_wdata),
        .ld_word     (w_rword),
        .byte_mask   (w_wmask),
        .st_lanes    (w_wrep),
        .ld_data     (w_rload),
        .misalign    (w_misalign)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (busReq) begin
                    if (WAIT_STATES == 0) begin
                        w_state_next = RESP;
                    end else begin
                        w_state_next = WAIT;
                        w_cnt_next   = c_wait_init;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - WAIT_CNT_W'(1);
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_enter_resp = (w_state_next == RESP) && (r_state != RESP);
    // Gating by reset_n keeps a reset that overlaps the commit edge from writing.
    assign w_commit     = w_enter_resp & w_we & ~w_err & reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= SZ_BYTE;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_in_idle && busReq) begin
                r_addr  <= busAddr;
                r_wdata <= busWData;
                r_we    <= busWe;
                r_uns   <= busUnsigned;
                r_size  <= bus_size_e'(busSize);
            end
            if (w_enter_resp) begin
                r_err <= w_err;
                if (w_err) begin
                    r_rdata <= '0;
                end else if (!w_we) begin
                    r_rdata <= w_rload;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_commit && w_wmask[i]) begin
                r_mem[w_idx][8*i +: 8] <= w_wrep[8*i +: 8];
            end
        end
    end

    assign busReady = (r_state == RESP);
    assign busErr   = (r_state == RESP) & r_err;
    assign busRData = r_rdata;

`ifdef BUS_RAM_STATS_EN
    logic [15:0] r_rd_cnt, r_wr_cnt, r_err_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_err_cnt <= '0;
        end else if (r_state == RESP) begin
            if (r_err) begin
                if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            end else if (r_we) begin
                if (r_wr_cnt != 16'hFFFF)  r_wr_cnt  <= r_wr_cnt + 16'd1;
            end else begin
                if (r_rd_cnt != 16'hFFFF)  r_rd_cnt  <= r_rd_cnt + 16'd1;
            end
        end
    end

    assign rdCount  = r_rd_cnt;
    assign wrCount  = r_wr_cnt;
    assign errCount = r_err_cnt;
`endif

endmodule : bus_ram_responder
`default_nettype wire

// File: tb/tb_bus_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_ram_responder
// Purpose  : Directed self-checking bench; one instance with one wait state,
//            one with none. Stats checks compiled in with BUS_RAM_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_ram_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req1, req0, we, uns;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
    logic [31:0] rdata1, rdata0;
    logic        ready1, err1, ready0, err0;
`ifdef BUS_RAM_STATS_EN
    logic [15:0] rd1, wr1, ec1, rd0, wr0, ec0;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bus_ram_responder #(.ADDR_WIDTH(8), .BASE_ADDR(32'h1000_0000), .WAIT_STATES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .busReq(req1), .busWe(we), .busAddr(addr),
        .busWData(wdata), .busSize(size), .busUnsigned(uns),
        .busRData(rdata1), .busReady(ready1), .busErr(err1)
`ifdef BUS_RAM_STATS_EN
        , .rdCount(rd1), .wrCount(wr1), .errCount(ec1)
`endif
    );

    bus_ram_responder #(.ADDR_WIDTH(8), .BASE_ADDR(32'h1000_0000), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .busReq(req0), .busWe(we), .busAddr(addr),
        .busWData(wdata), .busSize(size), .busUnsigned(uns),
        .busRData(rdata0), .busReady(ready0), .busErr(err0)
`ifdef BUS_RAM_STATS_EN
        , .rdCount(rd0), .wrCount(wr0), .errCount(ec0)
`endif
    );

    // Runs one transaction on the one-wait-state instance; lat counts cycles
    // from the accepting edge to the negedge where busReady is seen.
    task automatic txn1(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                        input logic [1:0] t_size, input logic t_uns,
                        output logic [31:0] o_rdata, output logic o_err, output int o_lat);
        @(negedge clk);
        we = t_we; addr = t_addr; wdata = t_wdata; size = t_size; uns = t_uns; req1 = 1'b1;
        o_lat = 0; o_rdata = 32'h0; o_err = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ready1) begin
                o_lat = i; o_rdata = rdata1; o_err = err1;
                break;
            end
        end
        req1 = 1'b0;
        if (o_lat == 0) begin
            tests++; fails++;
            $display("FAIL txn_timeout addr=%h: no busReady within 20 cycles", t_addr);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req1 = 1'b0; req0 = 1'b0;
        we = 1'b0; addr = '0; wdata = '0; size = 2'b10; uns = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (ready1 !== 1'b0) begin fails++; $display("FAIL reset_ready1 got=%b exp=0", ready1); end
        tests++; if (err1 !== 1'b0) begin fails++; $display("FAIL reset_err1 got=%b exp=0", err1); end
        tests++; if (rdata1 !== 32'h0) begin fails++; $display("FAIL reset_rdata1 got=%h exp=0", rdata1); end
        tests++; if (ready0 !== 1'b0) begin fails++; $display("FAIL reset_ready0 got=%b exp=0", ready0); end
        tests++; if (err0 !== 1'b0) begin fails++; $display("FAIL reset_err0 got=%b exp=0", err0); end
        tests++; if (rdata0 !== 32'h0) begin fails++; $display("FAIL reset_rdata0 got=%h exp=0", rdata0); end
        reset_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; int seen;
        txn1(1'b1, 32'h1000_0000, 32'h1122_3344, 2'b10, 1'b0, rd, er, lat);
        tests++; if (er !== 1'b0) begin fails++; $display("FAIL rstmid_prewrite_err got=%b exp=0", er); end
        @(negedge clk);
        we = 1'b1; addr = 32'h1000_0000; wdata = 32'hAABB_CCDD; size = 2'b10; req1 = 1'b1;
        @(negedge clk);
        reset_n = 1'b0; req1 = 1'b0;
        seen = 0;
        repeat (3) begin @(negedge clk); if (ready1) seen++; end
        reset_n = 1'b1;
        repeat (3) begin @(negedge clk); if (ready1) seen++; end
        tests++; if (seen !== 0) begin fails++; $display("FAIL rstmid_no_ready got=%0d pulses exp=0", seen); end
        txn1(1'b0, 32'h1000_0000, 32'h0, 2'b10, 1'b0, rd, er, lat);
        tests++; if (rd !== 32'h1122_3344) begin fails++; $display("FAIL rstmid_word_kept got=%h exp=11223344", rd); end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat;
        txn1(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 2'b10, 1'b0, rd, er, lat);
        tests++; if (lat !== 2) begin fails++; $display("FAIL sw_latency got=%0d exp=2", lat); end
        tests++; if (er !== 1'b0) begin fails++; $display("FAIL sw_err got=%b exp=0", er); end
        @(negedge clk);
        tests++; if (ready1 !== 1'b0) begin fails++; $display("FAIL ready_single_pulse got=%b exp=0", ready1); end
        txn1(1'b0, 32'h1000_0004, 32'h0, 2'b10, 1'b0, rd, er, lat);
        tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL lw_data got=%h exp=deadbeef", rd); end
        tests++; if (lat !== 2) begin fails++; $display("FAIL lw_latency got=%0d exp=2", lat); end
        tests++; if (er !== 1'b0) begin fails++; $display("FAIL lw_err got=%b exp=0", er); end
    endtask

    task automatic test_byte_half();
        logic [31:0] rd; logic er; int lat;
        txn1(1'b1, 32'h1000_0006, 32'h0000_0080, 2'b00, 1'b0, rd, er, lat);
        tests++; if (er !== 1'b0) begin fails++; $display("FAIL sb_err got=%b exp=0", er); end
        txn1(1'b0, 32'h1000_0004, 32'h0, 2'b10, 1'b0, rd, er, lat);
        tests++; if (rd !== 32'hDE80_BEEF) begin fails++; $display("FAIL sb_merge got=%h exp=de80beef", rd); end
        txn1(1'b0, 32'h1000_0006, 32'h0, 2'b00, 1'b0, rd, er, lat);
        tests++; if (rd !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_sext got=%h exp=ffffff80", rd); end
        txn1(1'b0, 32'h1000_0006, 32'h0, 2'b00, 1'b1, rd, er, lat);
        tests++; if (rd !== 32'h0000_0080) begin fails++; $display("FAIL lbu_zext got=%h exp=00000080", rd); end
        txn1(1'b0, 32'h1000_0007, 32'h0, 2'b00, 1'b0, rd, er, lat);
        tests++; if (rd !== 32'hFFFF_FFDE) begin fails++; $display("FAIL lb_lane3 got=%h exp=ffffffde", rd); end
        txn1(1'b0, 32'h1000_0006, 32'h0, 2'b01, 1'b0, rd, er, lat);
        tests++; if (rd !== 32'hFFFF_DE80) begin fails++; $display("FAIL lh_upper got=%h exp=ffffde80", rd); end
        txn1(1'b0, 32'h1000_0004, 32'h0, 2'b01, 1'b1, rd, er, lat);
        tests++; if (rd !== 32'h0000_BEEF) begin fails++; $display("FAIL lhu_lower got=%h exp=0000beef", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        txn1(1'b0, 32'h1000_0005, 32'h0, 2'b01, 1'b0, rd, er, lat);
        tests++; if (er !== 1'b1) begin fails++; $display("FAIL lh_misalign_err got=%b exp=1", er); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL lh_misalign_data got=%h exp=0", rd); end
        txn1(1'b1, 32'h2000_0004, 32'h1234_5678, 2'b10, 1'b0, rd, er, lat);
        tests++; if (er !== 1'b1) begin fails++; $display("FAIL sw_miss_err got=%b exp=1", er); end
        txn1(1'b1, 32'h1000_0003, 32'h0000_5555, 2'b01, 1'b0, rd, er, lat);
        tests++; if (er !== 1'b1) begin fails++; $display("FAIL sh_misalign_err got=%b exp=1", er); end
        txn1(1'b0, 32'h1000_0004, 32'h0, 2'b10, 1'b0, rd, er, lat);
        tests++; if (rd !== 32'hDE80_BEEF) begin fails++; $display("FAIL ram_unchanged got=%h exp=de80beef", rd); end
        txn1(1'b0, 32'h1000_0004, 32'h0, 2'b11, 1'b0, rd, er, lat);
        tests++; if (er !== 1'b1) begin fails++; $display("FAIL size_ill_err got=%b exp=1", er); end
        txn1(1'b0, 32'h1000_0006, 32'h0, 2'b10, 1'b0, rd, er, lat);
        tests++; if (er !== 1'b1) begin fails++; $display("FAIL lw_misalign_err got=%b exp=1", er); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL lw_misalign_data got=%h exp=0", rd); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        we = 1'b1; addr = 32'h1000_0010; wdata = 32'hCAFE_F00D; size = 2'b10; uns = 1'b0; req0 = 1'b1;
        @(negedge clk);
        tests++; if (ready0 !== 1'b1) begin fails++; $display("FAIL b2b_sw_ready got=%b exp=1", ready0); end
        tests++; if (err0 !== 1'b0) begin fails++; $display("FAIL b2b_sw_err got=%b exp=0", err0); end
        we = 1'b0; wdata = 32'h0;
        @(negedge clk);
        tests++; if (ready0 !== 1'b0) begin fails++; $display("FAIL b2b_idle_gap got=%b exp=0", ready0); end
        @(negedge clk);
        tests++; if (ready0 !== 1'b1) begin fails++; $display("FAIL b2b_lw_ready got=%b exp=1", ready0); end
        tests++; if (rdata0 !== 32'hCAFE_F00D) begin fails++; $display("FAIL b2b_lw_data got=%h exp=cafef00d", rdata0); end
        req0 = 1'b0;
        @(negedge clk);
        tests++; if (ready0 !== 1'b0) begin fails++; $display("FAIL b2b_done got=%b exp=0", ready0); end
    endtask

`ifdef BUS_RAM_STATS_EN
    task automatic test_stats();
        logic [31:0] rd; logic er; int lat;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        txn1(1'b0, 32'h1000_0004, 32'h0, 2'b10, 1'b0, rd, er, lat);
        txn1(1'b1, 32'h1000_0008, 32'h0000_0001, 2'b10, 1'b0, rd, er, lat);
        txn1(1'b0, 32'h1000_0006, 32'h0, 2'b00, 1'b0, rd, er, lat);
        txn1(1'b0, 32'h1000_0005, 32'h0, 2'b01, 1'b0, rd, er, lat);
        txn1(1'b1, 32'h1000_000C, 32'h0000_00AA, 2'b00, 1'b0, rd, er, lat);
        txn1(1'b0, 32'h1000_0004, 32'h0, 2'b01, 1'b1, rd, er, lat);
        @(negedge clk);
        tests++; if (rd1 !== 16'd3) begin fails++; $display("FAIL stats_rd got=%0d exp=3", rd1); end
        tests++; if (wr1 !== 16'd2) begin fails++; $display("FAIL stats_wr got=%0d exp=2", wr1); end
        tests++; if (ec1 !== 16'd1) begin fails++; $display("FAIL stats_err got=%0d exp=1", ec1); end
        tests++; if (rd0 !== 16'd0) begin fails++; $display("FAIL stats_idle_inst got=%0d exp=0", rd0); end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid();
        test_store_load();
        test_byte_half();
        test_errors();
        test_back_to_back();
`ifdef BUS_RAM_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_bus_ram_responder
`default_nettype wire
